uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter among NUM_REQ (2..4)
// byte producers. One byte is accepted per grant, launched with a single
// tx_data_en strobe, and the transmitter's tx_busy is tracked through the
// whole frame before the next arbitration.
//
// Optional feature, macro UART_ARB_TAG_EN: each grant first sends a tag
// byte {4'hA, 2'b00, id} and then the payload byte, without re-arbitrating.
// With the macro undefined only the payload byte is sent and the tag state
// does not exist.
//
// Handshake (req/ack): req[i] acts as "valid" and must stay high, with
// req_data slot i stable, until ack[i] pulses for one cycle. ack[i] is the
// "ready" strobe: the byte was captured on the clock edge that raised ack[i].
// The requester may present its next byte in the cycle after ack[i]; a req
// that drops before its ack is simply not served.

module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_data,
    output logic                 tx_data_en,
    input  logic                 tx_busy,
    output logic                 active,
    output logic [1:0]           cur_id,
    output logic                 start_err,
    output logic [2:0]           o_dbg_state
);

    // State encoding is fixed so the debug port has stable values.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3
`ifdef UART_ARB_TAG_EN
        ,
        S_TAG     = 3'd4
`endif
    } state_t;

    localparam logic [7:0] TIMEOUT_L  = 8'(START_TIMEOUT);
    localparam logic [1:0] LAST_RESET = 2'(NUM_REQ - 1);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_ack;
    logic [7:0]           r_hold;
    logic [7:0]           r_tx_data;
    logic                 r_tx_data_en;
    logic                 r_active;
    logic [1:0]           r_cur_id;
    logic [1:0]           r_last;
    logic                 r_start_err;
    logic [7:0]           r_cnt;
`ifdef UART_ARB_TAG_EN
    logic                 r_pay_pend;
`endif

    logic                 w_found;
    logic [1:0]           w_win;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [7:0]           w_byte;

    // Index of the k-th candidate after the last winner, wrapped into range.
    function automatic int rr_idx(input logic [1:0] last, input int k);
        int s;
        s = int'(last) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s;
    endfunction

    // Round-robin search starting at last+1; first high req wins.
    always_comb begin
        w_found  = 1'b0;
        w_win    = 2'd0;
        w_onehot = '0;
        w_byte   = 8'h00;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req[rr_idx(r_last, k)]) begin
                w_found                     = 1'b1;
                w_win                       = 2'(rr_idx(r_last, k));
                w_onehot[rr_idx(r_last, k)] = 1'b1;
                w_byte                      = req_data[8*rr_idx(r_last, k) +: 8];
            end
        end
    end

    // Main controller: arbitration, launch strobe, busy tracking, timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_ack        <= '0;
            r_hold       <= 8'h00;
            r_tx_data    <= 8'h00;
            r_tx_data_en <= 1'b0;
            r_active     <= 1'b0;
            r_cur_id     <= 2'd0;
            r_last       <= LAST_RESET;
            r_start_err  <= 1'b0;
            r_cnt        <= 8'd0;
`ifdef UART_ARB_TAG_EN
            r_pay_pend   <= 1'b0;
`endif
        end else begin
            // Strobes default low; each is raised for exactly one cycle.
            r_ack        <= '0;
            r_tx_data_en <= 1'b0;
            r_start_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // No grant while the transmitter is still busy.
                    if (!tx_busy && w_found) begin
                        r_ack    <= w_onehot;
                        r_hold   <= w_byte;
                        r_cur_id <= w_win;
                        r_last   <= w_win;
                        r_active <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        r_pay_pend <= 1'b1;
                        r_state    <= S_TAG;
`else
                        r_state    <= S_LAUNCH;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                S_TAG: begin
                    // Tag frame identifies the requester ahead of its payload.
                    r_tx_data    <= {4'hA, 2'b00, r_cur_id};
                    r_tx_data_en <= 1'b1;
                    r_cnt        <= 8'd0;
                    r_state      <= S_WAIT_HI;
                end
`endif
                S_LAUNCH: begin
                    // tx_data keeps this byte until the next launch.
                    r_tx_data    <= r_hold;
                    r_tx_data_en <= 1'b1;
                    r_cnt        <= 8'd0;
`ifdef UART_ARB_TAG_EN
                    r_pay_pend   <= 1'b0;
`endif
                    r_state      <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_cnt + 8'd1 == TIMEOUT_L) begin
                        // Transmitter never started: drop the byte(s), no retry.
                        r_start_err <= 1'b1;
                        r_active    <= 1'b0;
                        r_cnt       <= 8'd0;
`ifdef UART_ARB_TAG_EN
                        r_pay_pend  <= 1'b0;
`endif
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WAIT_LO: begin
                    // Frame length is set by the baud rate, so no timeout here.
                    if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
                        if (r_pay_pend) begin
                            r_state <= S_LAUNCH;
                        end else begin
                            r_active <= 1'b0;
                            r_state  <= S_IDLE;
                        end
`else
                        r_active <= 1'b0;
                        r_state  <= S_IDLE;
`endif
                    end
                end
                default: begin
                    r_active <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack;
    assign tx_data     = r_tx_data;
    assign tx_data_en  = r_tx_data_en;
    assign active      = r_active;
    assign cur_id      = r_cur_id;
    assign start_err   = r_start_err;
    assign o_dbg_state = r_state;

endmodule
